// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-index width and the source/destination match helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 4;

    typedef enum logic {
        ST_RUN,
        ST_MEM_WAIT
    } state_t;

    // True when a valid source register is about to be written by a stage.
    function automatic logic src_match(
        input logic             src_vld,
        input logic [REG_W-1:0] src,
        input logic             wb_en,
        input logic [REG_W-1:0] dest
    );
        return src_vld & wb_en & (dest == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline register observations in, stage
// freeze/flush controls, time-out flag and performance counters out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             fwd_en;
    logic [REG_W-1:0] id_src1;
    logic             id_src1_vld;
    logic [REG_W-1:0] id_src2;
    logic             id_src2_vld;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_rd;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_busy;
    logic             cnt_clr;

    logic             freeze_front;
    logic             bubble_id;
    logic             flush_if;
    logic             freeze_all;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output fwd_en, id_src1, id_src1_vld, id_src2, id_src2_vld,
               exe_dest, exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en,
               branch_taken, mem_busy, cnt_clr,
        input  freeze_front, bubble_id, flush_if, freeze_all,
               err_timeout, stall_cnt, bubble_cnt, flush_cnt
    );

    modport slave (
        input  fwd_en, id_src1, id_src1_vld, id_src2, id_src2_vld,
               exe_dest, exe_wb_en, exe_mem_rd, mem_dest, mem_wb_en,
               branch_taken, mem_busy, cnt_clr,
        output freeze_front, bubble_id, flush_if, freeze_all,
               err_timeout, stall_cnt, bubble_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: RAW hazard detection, branch flush,
// whole-pipe freeze on memory wait with time-out, and perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hc
);

    localparam int unsigned     WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_ctr;
    logic [WAIT_W-1:0] wait_nxt;
    logic              err_timeout;

    logic exe_hit;
    logic mem_hit;
    logic hazard;

    logic freeze_front;
    logic bubble_id;
    logic flush_if;
    logic freeze_all;

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        exe_hit = src_match(hc.id_src1_vld, hc.id_src1, hc.exe_wb_en, hc.exe_dest)
                | src_match(hc.id_src2_vld, hc.id_src2, hc.exe_wb_en, hc.exe_dest);
        mem_hit = src_match(hc.id_src1_vld, hc.id_src1, hc.mem_wb_en, hc.mem_dest)
                | src_match(hc.id_src2_vld, hc.id_src2, hc.mem_wb_en, hc.mem_dest);
        if (hc.fwd_en) begin
            hazard = exe_hit & hc.exe_mem_rd;
        end else begin
            hazard = exe_hit | mem_hit;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_ctr;
        unique case (state)
            ST_RUN: begin
                if (hc.mem_busy) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!hc.mem_busy) begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                end else if (wait_ctr != WAIT_MAX) begin
                    wait_nxt = wait_ctr + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Busy drop releases the pipe in the same cycle, so the stage controls
    // depend only on the live inputs; state just tracks the wait length.
    always_comb begin
        freeze_front = 1'b0;
        bubble_id    = 1'b0;
        flush_if     = 1'b0;
        freeze_all   = 1'b0;
        if (!rst) begin
            if (hc.mem_busy) begin
                freeze_all = 1'b1;
            end else if (hc.branch_taken) begin
                flush_if  = 1'b1;
                bubble_id = 1'b1;
            end else if (hazard) begin
                freeze_front = 1'b1;
                bubble_id    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_ctr <= '0;
        end else begin
            state    <= state_nxt;
            wait_ctr <= wait_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (hc.cnt_clr) begin
            err_timeout <= 1'b0;
        end else if (wait_nxt == WAIT_MAX) begin
            err_timeout <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_all),
        .clr (hc.cnt_clr),
        .q   (hc.stall_cnt)
    );

    // Data-hazard bubbles are exactly the cycles that also freeze the front.
    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (freeze_front),
        .clr (hc.cnt_clr),
        .q   (hc.bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_if),
        .clr (hc.cnt_clr),
        .q   (hc.flush_cnt)
    );

    assign hc.freeze_front = freeze_front;
    assign hc.bubble_id    = bubble_id;
    assign hc.flush_if     = flush_if;
    assign hc.freeze_all   = freeze_all;
    assign hc.err_timeout  = err_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short time-out and narrow
// counters so saturation and time-out are reachable quickly.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_hazard_ctrl_if #(.CNT_W(4)) hc ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input int ff, input int bid,
                        input int fi, input int fa);
        chk({tag, ".freeze_front"}, int'(hc.freeze_front), ff);
        chk({tag, ".bubble_id"},    int'(hc.bubble_id),    bid);
        chk({tag, ".flush_if"},     int'(hc.flush_if),     fi);
        chk({tag, ".freeze_all"},   int'(hc.freeze_all),   fa);
    endtask

    task automatic cnts(input string tag, input int st, input int bu, input int fl);
        chk({tag, ".stall_cnt"},  int'(hc.stall_cnt),  st);
        chk({tag, ".bubble_cnt"}, int'(hc.bubble_cnt), bu);
        chk({tag, ".flush_cnt"},  int'(hc.flush_cnt),  fl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hc.fwd_en       = 1'b0;
        hc.id_src1      = 4'd0;
        hc.id_src1_vld  = 1'b0;
        hc.id_src2      = 4'd0;
        hc.id_src2_vld  = 1'b0;
        hc.exe_dest     = 4'd0;
        hc.exe_wb_en    = 1'b0;
        hc.exe_mem_rd   = 1'b0;
        hc.mem_dest     = 4'd0;
        hc.mem_wb_en    = 1'b0;
        hc.branch_taken = 1'b0;
        hc.mem_busy     = 1'b0;
        hc.cnt_clr      = 1'b0;
    endtask

    task automatic exe_hazard();
        hc.exe_dest    = 4'd3;
        hc.exe_wb_en   = 1'b1;
        hc.id_src1     = 4'd3;
        hc.id_src1_vld = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        idle();
        rst = 1'b1;
        hc.mem_busy = 1'b1;
        #1;
        outs("reset_busy", 0, 0, 0, 0);
        tick();
        tick();
        cnts("reset", 0, 0, 0);
        chk("reset.err_timeout", int'(hc.err_timeout), 0);
        idle();
        rst = 1'b0;

        // Non-forwarding RAW on EXE dest
        exe_hazard();
        #1;
        outs("t1_exe", 1, 1, 0, 0);
        chk("t1_exe.bubble_pre", int'(hc.bubble_cnt), 0);
        tick();
        chk("t1_exe.bubble_post", int'(hc.bubble_cnt), 1);

        // Non-forwarding RAW on MEM dest via second source
        idle();
        hc.id_src2 = 4'd5; hc.id_src2_vld = 1'b1;
        hc.mem_dest = 4'd5; hc.mem_wb_en = 1'b1;
        #1;
        outs("t1_mem", 1, 1, 0, 0);
        tick();
        chk("t1_mem.bubble", int'(hc.bubble_cnt), 2);
        hc.id_src2_vld = 1'b0;
        #1;
        outs("t1_novld", 0, 0, 0, 0);
        tick();
        chk("t1_novld.bubble", int'(hc.bubble_cnt), 2);

        // Forwarding: only load-use in EXE stalls
        idle();
        hc.fwd_en = 1'b1;
        exe_hazard();
        #1;
        outs("t2_alu", 0, 0, 0, 0);
        tick();
        hc.exe_mem_rd = 1'b1;
        #1;
        outs("t2_load", 1, 1, 0, 0);
        tick();
        chk("t2_load.bubble", int'(hc.bubble_cnt), 3);
        idle();
        hc.fwd_en = 1'b1;
        hc.mem_dest = 4'd3; hc.mem_wb_en = 1'b1;
        hc.id_src1 = 4'd3; hc.id_src1_vld = 1'b1;
        #1;
        outs("t2_memfwd", 0, 0, 0, 0);
        tick();
        chk("t2_memfwd.bubble", int'(hc.bubble_cnt), 3);

        // Branch beats hazard
        idle();
        exe_hazard();
        hc.branch_taken = 1'b1;
        #1;
        outs("t3_branch", 0, 1, 1, 0);
        tick();
        cnts("t3_branch", 0, 3, 1);

        // Memory wait defers a pending branch; time-out trips on 4th busy edge
        idle();
        hc.branch_taken = 1'b1;
        hc.mem_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            outs($sformatf("t4_busy%0d", i), 0, 0, 0, 1);
            tick();
            chk($sformatf("t4_err%0d", i), int'(hc.err_timeout), (i >= 4) ? 1 : 0);
        end
        hc.mem_busy = 1'b0;
        #1;
        outs("t4_release", 0, 1, 1, 0);
        tick();
        cnts("t4_release", 5, 3, 2);
        chk("t4_err_sticky", int'(hc.err_timeout), 1);

        hc.branch_taken = 1'b0;
        hc.cnt_clr = 1'b1;
        tick();
        cnts("clr", 0, 0, 0);
        chk("clr.err_timeout", int'(hc.err_timeout), 0);
        hc.cnt_clr = 1'b0;

        // Six-cycle wait: error sticks after release until cleared
        hc.mem_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("t5_err%0d", i), int'(hc.err_timeout), (i >= 4) ? 1 : 0);
        end
        hc.mem_busy = 1'b0;
        #1;
        outs("t5_release", 0, 0, 0, 0);
        tick();
        chk("t5_err_after", int'(hc.err_timeout), 1);
        chk("t5_stall", int'(hc.stall_cnt), 6);

        // Clear wins over a same-cycle increment
        exe_hazard();
        hc.cnt_clr = 1'b1;
        tick();
        cnts("t5_clrwins", 0, 0, 0);
        chk("t5_clrwins.err", int'(hc.err_timeout), 0);
        hc.cnt_clr = 1'b0;

        // Saturation at 15 after 20 hazard cycles
        for (int i = 0; i < 20; i++) tick();
        chk("t6_sat", int'(hc.bubble_cnt), 15);

        // Asynchronous reset in the middle of a wait
        idle();
        hc.mem_busy = 1'b1;
        tick();
        tick();
        chk("t6_prewait_stall", int'(hc.stall_cnt), 2);
        rst = 1'b1;
        #1;
        outs("t6_rst", 0, 0, 0, 0);
        cnts("t6_rst", 0, 0, 0);
        tick();
        rst = 1'b0;
        // Wait count must have restarted: three more busy edges stay under 4
        for (int i = 1; i <= 3; i++) tick();
        chk("t6_waitreset.err", int'(hc.err_timeout), 0);
        chk("t6_waitreset.stall", int'(hc.stall_cnt), 3);
        tick();
        chk("t6_4th.err", int'(hc.err_timeout), 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
